sia_txq: RTL

Transmit half of the SIA V.4-compatible bit-serial port: a FIFO of pre-formatted frames feeding a shift-register transmitter that drives TXD and an optional TXC bit clock. Words are pushed by the Wishbone register block and serialized LSB-first at a programmable bit period, so any far-end receiver clocking on TXD edges or TXC rising edges samples mid-bit. Start and stop bits are part of the pushed word; the block adds no framing of its own.

---
 rtl/sia_txq_pkg.sv | 14 +
 rtl/queue.sv | 54 +++++
 rtl/sia_transmitter.sv | 99 +++++++++
 rtl/sia_txq.sv | 61 ++++++
 4 files changed

// File: rtl/sia_txq_pkg.sv
// Shared definitions for the SIA transmit queue: frame-length field width and the
// clamp applied to the requested bit count at frame load.
package sia_txq_pkg;

    localparam int unsigned BitsWidth = 6;

    function automatic logic [BitsWidth-1:0] clamp_bits(input logic [BitsWidth-1:0] bits,
                                                        input int unsigned limit);
        logic [BitsWidth-1:0] lim;
        lim = BitsWidth'(limit);
        return (bits > lim) ? lim : bits;
    endfunction

endpackage

// File: rtl/queue.sv
// First-word-fall-through FIFO of 2^DEPTH_BITS words; pushes while full are dropped,
// pops while empty are ignored.
module queue #(
    parameter int unsigned DEPTH_BITS = 4,
    parameter int unsigned DATA_BITS  = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 oe_i,
    input  logic [DATA_BITS-1:0] dat_i,
    output logic [DATA_BITS-1:0] dat_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned Depth = 1 << DEPTH_BITS;

    logic [DATA_BITS-1:0] mem_q [Depth];
    logic [DEPTH_BITS:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS:0]  rd_ptr_q, rd_ptr_d;
    logic                 push_ok, pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                     (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    assign dat_o   = oe_i ? mem_q[rd_ptr_q[DEPTH_BITS-1:0]] : '0;

    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + (DEPTH_BITS+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + (DEPTH_BITS+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= dat_i;
        end
    end

endmodule

// File: rtl/sia_transmitter.sv
// Bit-serial shift engine: pops a pre-framed word, shifts it out LSB-first at a latched
// bit period and generates a bit clock whose rising edge falls mid-cell.
module sia_transmitter
    import sia_txq_pkg::*;
#(
    parameter int unsigned SHIFT_REG_WIDTH = 16,
    parameter int unsigned BAUD_RATE_WIDTH = 32,
    parameter int unsigned BRW             = BAUD_RATE_WIDTH - 1,
    parameter int unsigned SRW             = SHIFT_REG_WIDTH - 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [BitsWidth-1:0] bits_i,
    input  logic [BRW:0]         baud_i,
    input  logic [SRW:0]         dat_i,
    input  logic                 empty_i,
    output logic                 pop_o,
    output logic                 txd_o,
    output logic                 txc_o,
    output logic                 idle_o,
    output logic                 sample_o
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;
    localparam logic       Mark    = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [SRW:0]         shreg_q, shreg_d;
    logic [BitsWidth-1:0] bitcnt_q, bitcnt_d;
    logic [BRW:0]         period_q, period_d;
    logic [BRW:0]         baud_q, baud_d;
    logic [BitsWidth-1:0] load_cnt;
    logic [BRW+1:0]       cell_len, rise_at;

    assign load_cnt = clamp_bits(bits_i, SHIFT_REG_WIDTH);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        period_d = period_q;
        baud_d   = baud_q;
        pop_o    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty_i) begin
                    pop_o    = 1'b1;
                    shreg_d  = dat_i;
                    baud_d   = baud_i;
                    bitcnt_d = load_cnt;
                    period_d = '0;
                    // A zero-length frame is consumed without leaving IDLE.
                    state_d  = (load_cnt == '0) ? StIdle : StShift;
                end
            end
            StShift: begin
                if (period_q == baud_q) begin
                    shreg_d  = {Mark, shreg_q[SRW:1]};
                    bitcnt_d = bitcnt_q - BitsWidth'(1);
                    period_d = '0;
                    if (bitcnt_q == BitsWidth'(1)) begin
                        state_d = StIdle;
                    end
                end else begin
                    period_d = period_q + (BRW+1)'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bit clock is low for the first ceil(P/2) clocks of each cell, high for the rest.
    always_comb begin
        cell_len = {1'b0, baud_q} + (BRW+2)'(1);
        rise_at  = cell_len - (cell_len >> 1);
        idle_o   = (state_q == StIdle);
        txd_o    = idle_o ? Mark : shreg_q[0];
        txc_o    = idle_o ? Mark : ({1'b0, period_q} >= rise_at);
        sample_o = !idle_o && ({1'b0, period_q} == rise_at);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            shreg_q  <= '1;
            bitcnt_q <= '0;
            period_q <= '0;
            baud_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            period_q <= period_d;
            baud_q   <= baud_d;
        end
    end

endmodule

// File: rtl/sia_txq.sv
// SIA transmit path: frame FIFO feeding the bit-serial transmitter.
module sia_txq
    import sia_txq_pkg::*;
#(
    parameter int unsigned SHIFT_REG_WIDTH = 16,
    parameter int unsigned BAUD_RATE_WIDTH = 32,
    parameter int unsigned DATA_BITS       = SHIFT_REG_WIDTH,
    parameter int unsigned DEPTH_BITS      = 4,
    parameter int unsigned BRW             = BAUD_RATE_WIDTH - 1,
    parameter int unsigned SRW             = SHIFT_REG_WIDTH - 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [BitsWidth-1:0] bits_i,
    input  logic [BRW:0]         baud_i,
    input  logic [SRW:0]         txq_dat_i,
    input  logic                 txq_push_i,
    output logic                 txq_full_o,
    output logic                 txq_empty_o,
    output logic                 txd_o,
    output logic                 txc_o,
    output logic                 idle_o
);

    logic [DATA_BITS-1:0] head_dat;
    logic                 tx_pop;
    logic                 unused_sample;

    queue #(
        .DEPTH_BITS (DEPTH_BITS),
        .DATA_BITS  (DATA_BITS)
    ) u_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (txq_push_i),
        .pop_i   (tx_pop),
        .oe_i    (1'b1),
        .dat_i   (txq_dat_i),
        .dat_o   (head_dat),
        .full_o  (txq_full_o),
        .empty_o (txq_empty_o)
    );

    sia_transmitter #(
        .SHIFT_REG_WIDTH (SHIFT_REG_WIDTH),
        .BAUD_RATE_WIDTH (BAUD_RATE_WIDTH)
    ) u_transmitter (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .bits_i   (bits_i),
        .baud_i   (baud_i),
        .dat_i    (head_dat),
        .empty_i  (txq_empty_o),
        .pop_o    (tx_pop),
        .txd_o    (txd_o),
        .txc_o    (txc_o),
        .idle_o   (idle_o),
        .sample_o (unused_sample)
    );

endmodule
